// File: rtl/wait_state_gen.sv
// Wait-state generator for a multiplexed processor bus: stretches READY low
// for a chip-select dependent number of cycles after each read/write strobe.
module wait_state_gen #(
    parameter int unsigned WS_MHIGH   = 2,
    parameter int unsigned WS_MLOW    = 1,
    parameter int unsigned WS_IO1     = 3,
    parameter int unsigned WS_IO2     = 4,
    parameter int unsigned WS_DEFAULT = 0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ALE,
    input  logic        RD_N,
    input  logic        WR_N,
    input  logic [3:0]  CS,
    input  logic        EXT_WAIT,
    input  logic        CLR_ERR,
    output logic        READY,
    output logic        BUSY,
    output logic        PROTO_ERR,
    output logic        MULTI_CS,
    output logic [15:0] WS_TOTAL,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] WS_BANK0 = 4'(WS_MHIGH);
    localparam logic [3:0] WS_BANK1 = 4'(WS_MLOW);
    localparam logic [3:0] WS_BANK2 = 4'(WS_IO1);
    localparam logic [3:0] WS_BANK3 = 4'(WS_IO2);
    localparam logic [3:0] WS_NONE  = 4'(WS_DEFAULT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        proto_q, proto_d;
    logic        multi_q, multi_d;
    logic [15:0] ws_total_q, ws_total_d;

    logic [3:0]  sel_ws;
    logic        multi_sel;
    logic        strobe;

    assign strobe    = !RD_N || !WR_N;
    assign multi_sel = ($countones(CS) > 1);

    // Several banks selected at once: honour the slowest of them.
    always_comb begin
        sel_ws = '0;
        if (CS == 4'b0000) begin
            sel_ws = WS_NONE;
        end else begin
            if (CS[0] && WS_BANK0 > sel_ws) sel_ws = WS_BANK0;
            if (CS[1] && WS_BANK1 > sel_ws) sel_ws = WS_BANK1;
            if (CS[2] && WS_BANK2 > sel_ws) sel_ws = WS_BANK2;
            if (CS[3] && WS_BANK3 > sel_ws) sel_ws = WS_BANK3;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        proto_d    = proto_q && !CLR_ERR;
        multi_d    = multi_q && !CLR_ERR;
        ws_total_d = ws_total_q;
        if (!ready_q && ws_total_q != 16'hFFFF) ws_total_d = ws_total_q + 16'd1;

        if (state_q == S_IDLE) begin
            ready_d = 1'b1;
            if (ALE) state_d = S_ARM;
        end else if (ALE) begin
            // A new address phase inside an active cycle aborts it; error beats CLR_ERR.
            proto_d = 1'b1;
            state_d = S_ARM;
            ready_d = 1'b1;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_ARM: begin
                    if (strobe) begin
                        if (multi_sel) multi_d = 1'b1;
                        if (sel_ws == 4'd0) begin
                            state_d = S_DONE;
                            ready_d = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = sel_ws;
                            ready_d = 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        if (!EXT_WAIT) begin
                            state_d = S_DONE;
                            ready_d = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (RD_N && WR_N) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            proto_q    <= 1'b0;
            multi_q    <= 1'b0;
            ws_total_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            proto_q    <= proto_d;
            multi_q    <= multi_d;
            ws_total_q <= ws_total_d;
        end
    end

    assign READY     = ready_q;
    assign BUSY      = (state_q != S_IDLE);
    assign PROTO_ERR = proto_q;
    assign MULTI_CS  = multi_q;
    assign WS_TOTAL  = ws_total_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_wait_state_gen.sv
// Randomized bench for wait_state_gen, checked against a transaction-level
// model of wait-cycle counts and sticky flags.
module tb_wait_state_gen;

    localparam int WS_P [4] = '{2, 1, 3, 4};
    localparam int WS_DEF   = 0;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        ALE, RD_N, WR_N, EXT_WAIT, CLR_ERR;
    logic [3:0]  CS;
    logic        READY, BUSY, PROTO_ERR, MULTI_CS;
    logic [15:0] WS_TOTAL;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    int          exp_total;
    logic        exp_multi;
    logic        exp_proto;

    wait_state_gen #(
        .WS_MHIGH(2), .WS_MLOW(1), .WS_IO1(3), .WS_IO2(4), .WS_DEFAULT(0)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ALE(ALE), .RD_N(RD_N), .WR_N(WR_N),
        .CS(CS), .EXT_WAIT(EXT_WAIT), .CLR_ERR(CLR_ERR), .READY(READY),
        .BUSY(BUSY), .PROTO_ERR(PROTO_ERR), .MULTI_CS(MULTI_CS),
        .WS_TOTAL(WS_TOTAL), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait cycles the bus contract assigns to a chip-select pattern.
    function automatic int ws_for(input logic [3:0] cs);
        int best;
        if (cs == 4'b0000) return WS_DEF;
        best = 0;
        for (int i = 0; i < 4; i++)
            if (cs[i] && WS_P[i] > best) best = WS_P[i];
        return best;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ALE = 0; RD_N = 1; WR_N = 1; CS = 4'b0000; EXT_WAIT = 0; CLR_ERR = 0;
    endtask

    // One complete bus cycle: ALE, pre idle ARM cycles, strobe, wait, release.
    task automatic run_txn(input logic [3:0] cs, input int mode, input int pre,
                           input int ext, input int rel, input string tag);
        int n, eff_ext, low;
        logic [15:0] exp_low;
        n       = ws_for(cs);
        eff_ext = (n > 0) ? ext : 0;
        exp_q.push_back(16'(n + eff_ext));
        ALE = 1; step(); ALE = 0;
        check({tag, "_arm_busy"}, 16'(BUSY), 16'd1);
        check({tag, "_arm_ready"}, 16'(READY), 16'd1);
        repeat (pre) step();
        RD_N = (mode == 1); WR_N = (mode == 0); CS = cs;
        step();
        check({tag, "_strobe_busy"}, 16'(BUSY), 16'd1);
        if ($countones(cs) > 1) exp_multi = 1'b1;
        low = READY ? 0 : 1;
        for (int j = 1; j <= n + eff_ext + 1; j++) begin
            EXT_WAIT = (n > 0) && (j >= n) && (j < n + eff_ext);
            if (j == rel) begin RD_N = 1; WR_N = 1; end
            step();
            if (!READY) low++;
        end
        EXT_WAIT = 0; RD_N = 1; WR_N = 1; CS = 4'b0000;
        step();
        exp_total += n + eff_ext;
        exp_low = exp_q.pop_front();
        check({tag, "_low_cycles"}, 16'(low), exp_low);
        check({tag, "_ws_total"}, WS_TOTAL, 16'(exp_total));
        check({tag, "_multi_cs"}, 16'(MULTI_CS), 16'(exp_multi));
        check({tag, "_idle_state"}, 16'(state_dbg), 16'd0);
        check({tag, "_idle_busy"}, 16'(BUSY), 16'd0);
    endtask

    task automatic clr_pulse(input string tag);
        CLR_ERR = 1; step(); CLR_ERR = 0;
        exp_multi = 0; exp_proto = 0;
        check({tag, "_multi"}, 16'(MULTI_CS), 16'd0);
        check({tag, "_proto"}, 16'(PROTO_ERR), 16'd0);
    endtask

    initial begin
        idle_inputs();
        exp_total = 0; exp_multi = 0; exp_proto = 0;
        RESET_N = 0;
        #12;
        check("rst_ready", 16'(READY), 16'd1);
        check("rst_busy", 16'(BUSY), 16'd0);
        check("rst_total", WS_TOTAL, 16'd0);
        check("rst_flags", {14'd0, PROTO_ERR, MULTI_CS}, 16'd0);
        check("rst_state", 16'(state_dbg), 16'd0);
        RESET_N = 1;
        step();

        run_txn(4'b0001, 0, 0, 0, 99, "rd_mhigh");
        run_txn(4'b0000, 1, 1, 0, 99, "wr_default");
        run_txn(4'b1000, 0, 0, 3, 99, "ext_io2");
        run_txn(4'b0101, 2, 0, 0, 2, "multi");
        check("multi_set", 16'(MULTI_CS), 16'd1);
        clr_pulse("clr_multi");

        // ALE while waiting on I/O 1 aborts back to ARM
        ALE = 1; step(); ALE = 0;
        RD_N = 0; CS = 4'b0100; step();
        check("abort_wait_ready", 16'(READY), 16'd0);
        RD_N = 1; CS = 4'b0000; ALE = 1; step(); ALE = 0;
        exp_total += 1; exp_proto = 1;
        check("abort_ready", 16'(READY), 16'd1);
        check("abort_state", 16'(state_dbg), 16'd1);
        check("abort_proto", 16'(PROTO_ERR), 16'd1);
        check("abort_total", WS_TOTAL, 16'(exp_total));
        // error and clear together: error wins
        ALE = 1; CLR_ERR = 1; step(); ALE = 0; CLR_ERR = 0;
        check("err_beats_clr", 16'(PROTO_ERR), 16'd1);
        WR_N = 0; step(); WR_N = 1; step();
        check("abort_back_idle", 16'(state_dbg), 16'd0);
        clr_pulse("clr_proto");

        for (int t = 0; t < 40; t++) begin
            logic [3:0] cs;
            cs = 4'($urandom_range(0, 15));
            run_txn(cs, $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(1, 8), "rand");
            if (t % 10 == 9) clr_pulse("rand_clr");
        end

        // Asynchronous reset two cycles into a WAIT
        ALE = 1; step(); ALE = 0;
        RD_N = 0; CS = 4'b1000; step(); step();
        check("pre_rst_ready", 16'(READY), 16'd0);
        RESET_N = 0;
        #1;
        exp_total = 0; exp_multi = 0; exp_proto = 0;
        check("async_rst_ready", 16'(READY), 16'd1);
        check("async_rst_busy", 16'(BUSY), 16'd0);
        check("async_rst_total", WS_TOTAL, 16'(exp_total));
        idle_inputs();
        step(); step();
        RESET_N = 1;
        step();
        check("post_rst_state", 16'(state_dbg), 16'd0);
        run_txn(4'b0010, 0, 0, 0, 99, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
